video_timing_gen: RTL and testbench
===================================

// Module: video_timing_gen
// PURPOSE
//  Raster timing generator for the HDR video output path. Derives a pixel-rate
//  tick from clk50 and produces hsync/vsync/de plus x/y pixel coordinates.
//  Downstream HDR tone-mapping and output stages consume these coordinates.
//  The timing is 640x480@60 by default, with a 25 MHz pixel tick.
// PARAMETERS
//  PIX_DIV  2    clk50 cycles per pixel tick (>=1; 1 = tick every clock)
//  H_ACTIVE 640  active pixels/line;  H_FP 16; H_SYNC 96; H_BP 48
//  V_ACTIVE 480  active lines/frame;  V_FP 10; V_SYNC 2;  V_BP 33
//  HS_POL   0    hsync asserted level; VS_POL 0 vsync asserted level
// PORTS
//  clk50       in   1   system clock, 50 MHz
//  rst         in   1   synchronous, active-high reset
//  en          in   1   run request; sampled at frame boundary only
//  pix_tick    out  1   one-clk strobe, qualifies all raster outputs
//  hsync       out  1   horizontal sync, level per HS_POL
//  vsync       out  1   vertical sync, level per VS_POL
//  de          out  1   data enable, high in active area
//  x           out  11  pixel column 0..H_ACTIVE-1 (0 outside active)
//  y           out  10  pixel row 0..V_ACTIVE-1 (0 outside active)
//  frame_start out  1   one-clk pulse coincident with pix_tick at h=0,v=0
//  busy        out  1   high while a frame is in progress
// BEHAVIOUR
//  - Reset: div/h/v counters=0, state IDLE, pix_tick=0, de=0, x=y=0,
//    hsync=~HS_POL, vsync=~VS_POL, frame_start=0, busy=0.
//  - Tick divider: div_cnt 0..PIX_DIV-1 free-runs from reset. pix_tick=1 for
//    the clk where div_cnt==PIX_DIV-1. Divider runs in IDLE too.
//  - FSM: IDLE -> RUN on a pix_tick with en=1 (h=v=0, frame_start=1).
//    RUN -> IDLE on the tick that wraps h=H_TOT-1,v=V_TOT-1 when en=0.
//    If en=1 at that wrap, stay in RUN with a new frame_start.
//    en toggling mid-frame has no effect; the frame always completes.
//  - Counters (RUN, on pix_tick): h++ with wrap at H_TOT-1 ->0, then v++.
//    v wraps at V_TOT-1 ->0. H_TOT=sum of H_*, V_TOT=sum of V_*.
//  - Outputs are registered and update on the same clk as pix_tick, reflecting
//    the new h/v: de=(h<H_ACTIVE)&&(v<V_ACTIVE); x=de?h:0; y=de?v:0.
//    hsync=HS_POL when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC,
//    else ~HS_POL. vsync uses the analogous rule on v.
//  - IDLE: outputs held at reset values (except pix_tick, which keeps ticking).
//  - rst mid-frame returns to IDLE next clk. No partial-frame recovery.
//  - Widths: h is 11 bits, v is 10 bits. An elaboration $error fires if H_TOT
//    or V_TOT overflows its width, or if PIX_DIV<1.
// CONFIGURATION
//  VTG_TEST_PATTERN_EN defined: adds output rgb[23:0], registered alongside de.
//    The pattern is 8 vertical colour bars of width H_ACTIVE/8, in order:
//    white, yellow, cyan, green, magenta, red, blue, black (8'hFF/8'h00
//    channels). rgb=0 when de=0 and on reset.
//  Undefined: no rgb port, no bar logic.
// STRUCTURE
//  Package video_timing_pkg:
//    - VGA_640x480 timing constants
//    - typedef vtg_state_t {IDLE,RUN}
//    - typedef rgb888_t
//  Sub-module vtg_axis_counter (count, wrap flag, sync/active compares),
//  instantiated twice: horizontal and vertical.
// TESTING
//  - Reset, en=0 for 100 clk: pix_tick every 2nd clk; de=0; hsync=vsync=1;
//    busy=0.
//  - en=1 at reset release: first frame_start within 2 clk. The next
//    frame_start follows exactly 2*800*525=840000 clk later.
//  - Line timing: de high for 640 ticks. hsync low for ticks 656..751 of each
//    line. x runs 0..639 monotonically.
//  - Frame timing: vsync low on lines 490..491. y runs 0..479. de is never
//    high on lines 480..524.
//  - en dropped at line 100: frame completes to v=524,h=799, then IDLE/busy=0.
//    en re-raised: restart with h=v=0.
//  - rst pulsed at line 300: the next clk shows IDLE reset values.
//    With VTG_TEST_PATTERN_EN: x=80 -> rgb=24'hFFFF00, x=639 -> rgb=0.

Source files
------------

// File: rtl/video_timing_pkg.sv
// Shared timing constants, state and pixel types for the raster timing generator.
// Default timing is 640x480@60 with a 25 MHz pixel tick derived from 50 MHz.
package video_timing_pkg;

  localparam int VGA_PIX_DIV  = 2;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int H_W = 11;
  localparam int V_W = 10;

  typedef enum logic {IDLE, RUN} vtg_state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  // Bar order: white, yellow, cyan, green, magenta, red, blue, black.
  function automatic rgb888_t bar_colour(input logic [2:0] bar);
    rgb888_t c;
    c.r = {8{~bar[1]}};
    c.g = {8{~bar[2]}};
    c.b = {8{~bar[0]}};
    return c;
  endfunction

endpackage

// File: rtl/vtg_axis_counter.sv
// One raster axis: wrapping position counter plus active/sync decode of the
// value the counter takes on this clock, so the caller can register outputs.
module vtg_axis_counter
  import video_timing_pkg::*;
#(
  parameter int W      = H_W,
  parameter int ACTIVE = VGA_H_ACTIVE,
  parameter int FP     = VGA_H_FP,
  parameter int SYNC   = VGA_H_SYNC,
  parameter int BP     = VGA_H_BP
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         step,
  output logic         last,
  output logic [W-1:0] count_next,
  output logic         active_next,
  output logic         sync_next
);

  localparam int TOT = ACTIVE + FP + SYNC + BP;
  localparam logic [W-1:0] LAST_VAL = W'(TOT - 1);
  localparam logic [31:0] ACTIVE_END = 32'(ACTIVE);
  localparam logic [31:0] SYNC_LO    = 32'(ACTIVE + FP);
  localparam logic [31:0] SYNC_HI    = 32'(ACTIVE + FP + SYNC);

  logic [W-1:0] count;
  logic [31:0]  next32;

  assign last = (count == LAST_VAL);

  always_comb begin
    count_next = count;
    if (step) count_next = last ? '0 : count + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) count <= '0;
    else     count <= count_next;
  end

  // Decode on a 32-bit copy so a sync window ending exactly at 2**W still compares correctly.
  assign next32      = 32'(count_next);
  assign active_next = (next32 < ACTIVE_END);
  assign sync_next   = (next32 >= SYNC_LO) && (next32 < SYNC_HI);

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel tick divider, IDLE/RUN frame FSM, sync/de/x/y.
// Define VTG_TEST_PATTERN_EN to add an rgb output carrying 8 vertical colour bars.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int PIX_DIV  = VGA_PIX_DIV,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic        clk50,
  input  logic        rst,
  input  logic        en,
  output logic        pix_tick,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic        frame_start,
  output logic        busy
`ifdef VTG_TEST_PATTERN_EN
  ,
  output rgb888_t     rgb
`endif
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

  if (H_TOT > 2**H_W || V_TOT > 2**V_W || PIX_DIV < 1) begin : g_bad_cfg
    $error("video_timing_gen: H_TOT/V_TOT exceed counter width or PIX_DIV < 1");
  end

  logic [DIV_W-1:0] div_cnt, div_next;
  logic             tick;
  vtg_state_t       state, state_next;
  logic             run_step, start;
  logic             h_last, v_last;
  logic [H_W-1:0]   h_next;
  logic [V_W-1:0]   v_next;
  logic             h_active_n, v_active_n, h_sync_n, v_sync_n;
  logic             de_next;

  // The tick register goes high on the same clock the divider reaches its last count.
  assign div_next = (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
  assign tick     = (div_next == DIV_LAST);

  always_ff @(posedge clk50) begin
    if (rst) div_cnt <= '0;
    else     div_cnt <= div_next;
  end

  always_ff @(posedge clk50) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    run_step   = 1'b0;
    start      = 1'b0;
    case (state)
      IDLE: begin
        if (tick && en) begin
          state_next = RUN;
          start      = 1'b1;
        end
      end
      RUN: begin
        if (tick) begin
          run_step = 1'b1;
          if (h_last && v_last) begin
            if (en) start = 1'b1;
            else    state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  vtg_axis_counter #(
    .W(H_W), .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
  ) u_h (
    .clk(clk50), .rst(rst), .step(run_step), .last(h_last),
    .count_next(h_next), .active_next(h_active_n), .sync_next(h_sync_n)
  );

  vtg_axis_counter #(
    .W(V_W), .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
  ) u_v (
    .clk(clk50), .rst(rst), .step(run_step && h_last), .last(v_last),
    .count_next(v_next), .active_next(v_active_n), .sync_next(v_sync_n)
  );

  assign de_next = h_active_n && v_active_n;
  assign busy    = (state == RUN);

`ifdef VTG_TEST_PATTERN_EN
  localparam int BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
  logic [31:0] bar_idx;
  assign bar_idx = 32'(h_next) / 32'(BAR_W);

  always_ff @(posedge clk50) begin
    if (rst)                          rgb <= '0;
    else if (tick && state_next == RUN) rgb <= de_next ? bar_colour(bar_idx[2:0]) : '0;
    else if (tick)                    rgb <= '0;
  end
`endif

  // Raster outputs follow the new h/v on tick clocks and fall back to idle levels outside a frame.
  always_ff @(posedge clk50) begin
    if (rst) begin
      pix_tick    <= 1'b0;
      frame_start <= 1'b0;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
    end else begin
      pix_tick    <= tick;
      frame_start <= start;
      if (tick) begin
        if (state_next == RUN) begin
          de    <= de_next;
          x     <= de_next ? h_next : '0;
          y     <= de_next ? v_next : '0;
          hsync <= h_sync_n ? HS_POL : ~HS_POL;
          vsync <= v_sync_n ? VS_POL : ~VS_POL;
        end else begin
          de    <= 1'b0;
          x     <= '0;
          y     <= '0;
          hsync <= ~HS_POL;
          vsync <= ~VS_POL;
        end
      end
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: a reduced-timing instance (24x14 ticks/frame) for frame-level
// behaviour, and a default 640x480 instance for one full line of VGA timing.
module tb_video_timing_gen;

  logic        clk50 = 1'b0;
  logic        rst, en, en_v;
  logic        pix_tick, hsync, vsync, de, frame_start, busy;
  logic [10:0] x;
  logic [9:0]  y;
  logic        pix_tick_v, hsync_v, vsync_v, de_v, frame_start_v, busy_v;
  logic [10:0] x_v;
  logic [9:0]  y_v;
`ifdef VTG_TEST_PATTERN_EN
  logic [23:0] rgb, rgb_v;
`endif

  int checks = 0;
  int errors = 0;

  always #10 clk50 = ~clk50;

  // Small timing: H 16/2/3/3 (sync low h=18..20), V 8/2/2/2 (sync low v=10..11).
  video_timing_gen #(
    .PIX_DIV(2), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(2), .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .clk50(clk50), .rst(rst), .en(en), .pix_tick(pix_tick), .hsync(hsync),
    .vsync(vsync), .de(de), .x(x), .y(y), .frame_start(frame_start), .busy(busy)
`ifdef VTG_TEST_PATTERN_EN
    , .rgb(rgb)
`endif
  );

  video_timing_gen dut_vga (
    .clk50(clk50), .rst(rst), .en(en_v), .pix_tick(pix_tick_v), .hsync(hsync_v),
    .vsync(vsync_v), .de(de_v), .x(x_v), .y(y_v), .frame_start(frame_start_v), .busy(busy_v)
`ifdef VTG_TEST_PATTERN_EN
    , .rgb(rgb_v)
`endif
  );

  task automatic test_reset();
    bit exp_tick;
    rst = 1'b1; en = 1'b0; en_v = 1'b0;
    repeat (3) @(negedge clk50);
    checks++;
    if ({pix_tick, de, busy, frame_start, hsync, vsync} !== 6'b000011) begin
      errors++;
      $display("[TB] FAIL reset_ctrl got=%b exp=000011", {pix_tick, de, busy, frame_start, hsync, vsync});
    end
    checks++;
    if (x !== 11'd0 || y !== 10'd0) begin
      errors++;
      $display("[TB] FAIL reset_xy got x=%0d y=%0d exp 0 0", x, y);
    end
    checks++;
    if ({pix_tick_v, de_v, busy_v, frame_start_v, hsync_v, vsync_v} !== 6'b000011) begin
      errors++;
      $display("[TB] FAIL reset_vga got=%b exp=000011", {pix_tick_v, de_v, busy_v, frame_start_v, hsync_v, vsync_v});
    end
    rst = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk50);
      exp_tick = (k % 2 == 1);
      checks++;
      if (pix_tick !== exp_tick) begin
        errors++;
        $display("[TB] FAIL idle_tick k=%0d got=%b exp=%b", k, pix_tick, exp_tick);
      end
      checks++;
      if ({de, busy, hsync, vsync, frame_start} !== 5'b00110) begin
        errors++;
        $display("[TB] FAIL idle_outputs k=%0d got=%b exp=00110", k, {de, busy, hsync, vsync, frame_start});
      end
    end
    checks++;
    if ({de_v, busy_v, hsync_v, vsync_v} !== 4'b0011) begin
      errors++;
      $display("[TB] FAIL idle_vga got=%b exp=0011", {de_v, busy_v, hsync_v, vsync_v});
    end
  endtask

  task automatic test_frame();
    bit found;
    int h, v;
    bit exp_de, exp_hs, exp_vs, exp_fs;
    rst = 1'b1; en = 1'b1;
    repeat (3) @(negedge clk50);
    rst = 1'b0;
    found = 1'b0;
    for (int k = 1; k <= 2 && !found; k++) begin
      @(negedge clk50);
      if (frame_start === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL first_frame_start got=none exp=pulse within 2 clk");
    end
    checks++;
    if ({de, busy, x, y} !== {1'b1, 1'b1, 11'd0, 10'd0}) begin
      errors++;
      $display("[TB] FAIL frame_origin got de=%b busy=%b x=%0d y=%0d exp 1 1 0 0", de, busy, x, y);
    end
    h = 0; v = 0;
    for (int c = 1; c <= 672; c++) begin
      @(negedge clk50);
      if (c % 2 == 0) begin
        h++;
        if (h == 24) begin h = 0; v++; if (v == 14) v = 0; end
        exp_de = (h < 16) && (v < 8);
        exp_hs = !(h >= 18 && h <= 20);
        exp_vs = !(v >= 10 && v <= 11);
        exp_fs = (c == 672);
        checks++;
        if ({pix_tick, frame_start, de, hsync, vsync} !== {1'b1, exp_fs, exp_de, exp_hs, exp_vs}) begin
          errors++;
          $display("[TB] FAIL frame_ctrl c=%0d h=%0d v=%0d got=%b exp=%b", c, h, v,
                   {pix_tick, frame_start, de, hsync, vsync}, {1'b1, exp_fs, exp_de, exp_hs, exp_vs});
        end
        checks++;
        if (x !== 11'(exp_de ? h : 0) || y !== 10'(exp_de ? v : 0)) begin
          errors++;
          $display("[TB] FAIL frame_xy c=%0d got x=%0d y=%0d exp x=%0d y=%0d", c, x, y,
                   exp_de ? h : 0, exp_de ? v : 0);
        end
      end else begin
        checks++;
        if ({pix_tick, frame_start} !== 2'b00) begin
          errors++;
          $display("[TB] FAIL frame_offtick c=%0d got=%b exp=00", c, {pix_tick, frame_start});
        end
      end
    end
  endtask

  task automatic test_en_drop();
    int starts;
    bit found;
    for (int c = 1; c <= 672; c++) begin
      @(negedge clk50);
      if (c == 240) begin
        checks++;
        if ({de, x, y} !== {1'b1, 11'd0, 10'd5}) begin
          errors++;
          $display("[TB] FAIL drop_line5 got de=%b x=%0d y=%0d exp 1 0 5", de, x, y);
        end
        en = 1'b0;
      end
      if (c == 300) begin
        checks++;
        if ({busy, de, x, y} !== {1'b1, 1'b1, 11'd6, 10'd6}) begin
          errors++;
          $display("[TB] FAIL drop_midframe got busy=%b de=%b x=%0d y=%0d exp 1 1 6 6", busy, de, x, y);
        end
      end
      if (c == 670) begin
        checks++;
        if ({busy, pix_tick, de, hsync, vsync} !== 5'b11011) begin
          errors++;
          $display("[TB] FAIL drop_last_pixel got=%b exp=11011", {busy, pix_tick, de, hsync, vsync});
        end
      end
      if (c == 672) begin
        checks++;
        if ({busy, pix_tick, frame_start, de, x, y} !== {1'b0, 1'b1, 1'b0, 1'b0, 11'd0, 10'd0}) begin
          errors++;
          $display("[TB] FAIL drop_to_idle got busy=%b tick=%b fs=%b de=%b x=%0d y=%0d exp 0 1 0 0 0 0",
                   busy, pix_tick, frame_start, de, x, y);
        end
      end
    end
    starts = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk50);
      if (frame_start === 1'b1 || busy === 1'b1) starts++;
    end
    checks++;
    if (starts != 0) begin
      errors++;
      $display("[TB] FAIL drop_stays_idle got=%0d active clk exp=0", starts);
    end
    en = 1'b1;
    found = 1'b0;
    for (int k = 1; k <= 2 && !found; k++) begin
      @(negedge clk50);
      if (frame_start === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found || {busy, de, x, y} !== {1'b1, 1'b1, 11'd0, 10'd0}) begin
      errors++;
      $display("[TB] FAIL restart got fs=%b busy=%b de=%b x=%0d y=%0d exp 1 1 1 0 0",
               found, busy, de, x, y);
    end
  endtask

  task automatic test_rst_mid();
    repeat (154) @(negedge clk50);
    checks++;
    if ({busy, de, x, y} !== {1'b1, 1'b1, 11'd5, 10'd3}) begin
      errors++;
      $display("[TB] FAIL rst_pre got busy=%b de=%b x=%0d y=%0d exp 1 1 5 3", busy, de, x, y);
    end
    rst = 1'b1;
    @(negedge clk50);
    checks++;
    if ({busy, de, pix_tick, frame_start, hsync, vsync, x, y} !== {6'b000011, 11'd0, 10'd0}) begin
      errors++;
      $display("[TB] FAIL rst_mid got=%b x=%0d y=%0d exp=000011 0 0",
               {busy, de, pix_tick, frame_start, hsync, vsync}, x, y);
    end
    rst = 1'b0; en = 1'b0;
    repeat (10) @(negedge clk50);
    checks++;
    if ({busy, de} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL rst_stay_idle got=%b exp=00", {busy, de});
    end
  endtask

  task automatic test_vga_line();
    bit found;
    int h, de_ticks;
    bit exp_de, exp_hs;
    en_v = 1'b1;
    found = 1'b0;
    for (int k = 1; k <= 4 && !found; k++) begin
      @(negedge clk50);
      if (frame_start_v === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found || {de_v, x_v, y_v} !== {1'b1, 11'd0, 10'd0}) begin
      errors++;
      $display("[TB] FAIL vga_start got fs=%b de=%b x=%0d y=%0d exp 1 1 0 0", found, de_v, x_v, y_v);
    end
    h = 0;
    de_ticks = (de_v === 1'b1) ? 1 : 0;
    for (int c = 1; c <= 1600; c++) begin
      @(negedge clk50);
      if (c % 2 == 0) begin
        h++;
        if (h == 800) begin
          checks++;
          if ({de_v, x_v, y_v, hsync_v} !== {1'b1, 11'd0, 10'd1, 1'b1}) begin
            errors++;
            $display("[TB] FAIL vga_line1 got de=%b x=%0d y=%0d hs=%b exp 1 0 1 1", de_v, x_v, y_v, hsync_v);
          end
        end else begin
          exp_de = (h < 640);
          exp_hs = !(h >= 656 && h <= 751);
          if (de_v === 1'b1) de_ticks++;
          checks++;
          if ({de_v, hsync_v, vsync_v} !== {exp_de, exp_hs, 1'b1} || x_v !== 11'(exp_de ? h : 0) || y_v !== 10'd0) begin
            errors++;
            $display("[TB] FAIL vga_line0 h=%0d got de=%b hs=%b vs=%b x=%0d y=%0d exp %b %b 1 %0d 0",
                     h, de_v, hsync_v, vsync_v, x_v, y_v, exp_de, exp_hs, exp_de ? h : 0);
          end
`ifdef VTG_TEST_PATTERN_EN
          if (h == 80 || h == 639 || h == 700) begin
            checks++;
            if (rgb_v !== ((h == 80) ? 24'hFFFF00 : 24'h000000)) begin
              errors++;
              $display("[TB] FAIL vga_rgb h=%0d got=%h exp=%h", h, rgb_v, (h == 80) ? 24'hFFFF00 : 24'h000000);
            end
          end
`endif
        end
      end
    end
    checks++;
    if (de_ticks != 640) begin
      errors++;
      $display("[TB] FAIL vga_de_width got=%0d exp=640", de_ticks);
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_en_drop();
    test_rst_mid();
    test_vga_line();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
